// File: rtl/tpum_pkg.sv
// rtl/tpum_pkg.sv - shared types and constants for the TPUM XBOX row mover
package tpum_pkg;

  localparam int XBOX_ADDR_W = 14;
  localparam int XBOX_ROW_W  = 1024;
  localparam int RF_WORD_W   = 32;
  localparam int ROW_WORDS   = 32;

  typedef enum logic [1:0] {
    LOAD_R1  = 2'b00,
    LOAD_R2  = 2'b01,
    STORE_RA = 2'b10,
    RSVD     = 2'b11
  } mover_op_e;

  typedef enum logic [6:0] {
    ST_IDLE    = 7'b0000001,
    ST_RD_REQ  = 7'b0000010,
    ST_RD_WAIT = 7'b0000100,
    ST_UNPACK  = 7'b0001000,
    ST_GATHER  = 7'b0010000,
    ST_WR_REQ  = 7'b0100000,
    ST_FIN     = 7'b1000000
  } mover_state_e;

endpackage

// File: rtl/tpum_row_buffer.sv
// rtl/tpum_row_buffer.sv - one XBOX row of storage with full-row load and word access
module tpum_row_buffer
  import tpum_pkg::*;
#(
  parameter int WORD_W = RF_WORD_W,
  parameter int WORDS  = ROW_WORDS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [WORDS*WORD_W-1:0] load_data,
  input  logic                    wr_en,
  input  logic [4:0]              wr_idx,
  input  logic [WORD_W-1:0]       wr_data,
  input  logic [4:0]              rd_idx,
  output logic [WORD_W-1:0]       rd_data,
  output logic [WORDS*WORD_W-1:0] row
);

  logic [WORDS-1:0][WORD_W-1:0] row_q;

  // A full-row load and a word write never coincide; load is given priority anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
    end else if (load) begin
      row_q <= load_data;
    end else if (wr_en) begin
      row_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = row_q[rd_idx];
  assign row     = row_q;

endmodule

// File: rtl/tpum_xbox_row_mover.sv
// rtl/tpum_xbox_row_mover.sv - moves rows between XBOX and the R1/R2/RA word banks
module tpum_xbox_row_mover
  import tpum_pkg::*;
#(
  parameter int ADDR_W     = XBOX_ADDR_W,
  parameter int ROW_W      = XBOX_ROW_W,
  parameter int WORD_W     = RF_WORD_W,
  parameter int RD_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              done,
  output logic              err,
  output logic              xbox_rd,
  output logic              xbox_wr,
  output logic [ADDR_W-1:0] xbox_addr,
  output logic [ROW_W-1:0]  xbox_wdata,
  input  logic [ROW_W-1:0]  xbox_rdata,
  input  logic              xbox_rvalid,
  output logic              rf_wr_en,
  output logic              rf_wr_sel,
  output logic [4:0]        rf_wr_idx,
  output logic [WORD_W-1:0] rf_wr_data,
  output logic              rf_rd_en,
  output logic [4:0]        rf_rd_idx,
  input  logic [WORD_W-1:0] rf_rd_data
);

  localparam int TO_W  = $clog2(RD_TIMEOUT) + 1;
  localparam int WORDS = ROW_W / WORD_W;

  mover_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              sel_q;
  logic              err_q;
  logic [5:0]        cnt_q;
  logic [TO_W-1:0]   tcnt_q;
  logic              accept;
  logic              set_err;
  logic              buf_load;
  logic              buf_wr_en;
  logic              timeout;
  logic [4:0]        gather_idx;
  logic [WORD_W-1:0] buf_rd_data;

  // RA data arrives one cycle after its request, so gather writes trail the read index by one.
  assign gather_idx = cnt_q[4:0] - 5'd1;
  assign timeout    = (tcnt_q >= TO_W'(RD_TIMEOUT - 1));
  assign xbox_addr  = addr_q;

  tpum_row_buffer #(
    .WORD_W(WORD_W),
    .WORDS (WORDS)
  ) u_row_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (buf_load),
    .load_data(xbox_rdata),
    .wr_en    (buf_wr_en),
    .wr_idx   (gather_idx),
    .wr_data  (rf_rd_data),
    .rd_idx   (cnt_q[4:0]),
    .rd_data  (buf_rd_data),
    .row      (xbox_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    xbox_rd    = 1'b0;
    xbox_wr    = 1'b0;
    rf_wr_en   = 1'b0;
    rf_wr_sel  = 1'b0;
    rf_wr_idx  = '0;
    rf_wr_data = '0;
    rf_rd_en   = 1'b0;
    rf_rd_idx  = '0;
    accept     = 1'b0;
    set_err    = 1'b0;
    buf_load   = 1'b0;
    buf_wr_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept = 1'b1;
          unique case (mover_op_e'(cmd_op))
            LOAD_R1, LOAD_R2: state_d = ST_RD_REQ;
            STORE_RA:         state_d = ST_GATHER;
            default: begin
              state_d = ST_FIN;
              set_err = 1'b1;
            end
          endcase
        end
      end
      ST_RD_REQ: begin
        xbox_rd = 1'b1;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // Data arriving on the last allowed cycle still wins over the timeout.
        if (xbox_rvalid) begin
          buf_load = 1'b1;
          state_d  = ST_UNPACK;
        end else if (timeout) begin
          set_err = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_UNPACK: begin
        rf_wr_en   = 1'b1;
        rf_wr_sel  = sel_q;
        rf_wr_idx  = cnt_q[4:0];
        rf_wr_data = buf_rd_data;
        if (cnt_q == 6'd31) begin
          state_d = ST_FIN;
        end
      end
      ST_GATHER: begin
        if (!cnt_q[5]) begin
          rf_rd_en  = 1'b1;
          rf_rd_idx = cnt_q[4:0];
        end
        buf_wr_en = (cnt_q != 6'd0);
        if (cnt_q == 6'd32) begin
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        xbox_wr = 1'b1;
        state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = !err_q;
        err     = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      sel_q  <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      tcnt_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= cmd_addr;
        sel_q  <= cmd_op[0];
        err_q  <= 1'b0;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
      if (state_q == ST_UNPACK || state_q == ST_GATHER) begin
        cnt_q <= cnt_q + 6'd1;
      end else begin
        cnt_q <= '0;
      end
      if (state_q == ST_RD_WAIT) begin
        if (tcnt_q != TO_W'(RD_TIMEOUT)) begin
          tcnt_q <= tcnt_q + TO_W'(1);
        end
      end else begin
        tcnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tpum_xbox_row_mover.sv
// tb/tb_tpum_xbox_row_mover.sv - self-checking bench for tpum_xbox_row_mover
module tb_tpum_xbox_row_mover;
  import tpum_pkg::*;

  localparam int RD_TIMEOUT = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [13:0]   cmd_addr;
  logic          done;
  logic          err;
  logic          xbox_rd;
  logic          xbox_wr;
  logic [13:0]   xbox_addr;
  logic [1023:0] xbox_wdata;
  logic [1023:0] xbox_rdata;
  logic          xbox_rvalid;
  logic          rf_wr_en;
  logic          rf_wr_sel;
  logic [4:0]    rf_wr_idx;
  logic [31:0]   rf_wr_data;
  logic          rf_rd_en;
  logic [4:0]    rf_rd_idx;
  logic [31:0]   rf_rd_data;

  always #5 clk = ~clk;

  tpum_xbox_row_mover #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .done       (done),
    .err        (err),
    .xbox_rd    (xbox_rd),
    .xbox_wr    (xbox_wr),
    .xbox_addr  (xbox_addr),
    .xbox_wdata (xbox_wdata),
    .xbox_rdata (xbox_rdata),
    .xbox_rvalid(xbox_rvalid),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_sel  (rf_wr_sel),
    .rf_wr_idx  (rf_wr_idx),
    .rf_wr_data (rf_wr_data),
    .rf_rd_en   (rf_rd_en),
    .rf_rd_idx  (rf_rd_idx),
    .rf_rd_data (rf_rd_data)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic        sel;
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_ev_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [4:0]  idx;
  } rd_ev_t;

  typedef struct {
    logic [1:0]  op;
    logic [13:0] addr;
    int          lat;
    bit          hold;
    logic [31:0] base;
    int          t_end;
    bit          t_err;
    int          t_first_wr;
    int          t_nwr;
    int          t_xwr;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] row_w[32];
  logic [31:0] ra[32];

  wr_ev_t wr_q[$];
  wr_ev_t exp_wr[$];
  rd_ev_t rden_q[$];
  rd_ev_t exp_rden[$];
  int rd_n, rd_cyc, xwr_n, xwr_cyc;
  logic [13:0] rd_addr, xwr_addr;
  logic [1023:0] xwr_data;
  int done_n, err_n, overlap_n, act_end, ready_busy;
  bit act_is_err, ready_after;
  int exp_end, exp_xwr_cyc;
  bit exp_err, exp_rd, exp_xwr;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {cmd_ready, done, err, xbox_rd, xbox_wr, rf_wr_en, rf_wr_sel, rf_rd_en,
               xbox_addr, rf_wr_idx, rf_rd_idx, rf_wr_data}, {1'b1, 63'd0});
    chk({name, "_wdata"}, |xbox_wdata, 1'b0);
  endtask

  // Reference timeline derived from the command rules, in cycles after the acceptance edge.
  task automatic build_expect(input logic [1:0] op, input int lat);
    exp_wr.delete();
    exp_rden.delete();
    exp_rd = 0;
    exp_xwr = 0;
    exp_xwr_cyc = 0;
    exp_err = 0;
    if (op == 2'b11) begin
      exp_err = 1;
      exp_end = 1;
    end else if (op == 2'b10) begin
      for (int g = 0; g < 32; g++) exp_rden.push_back('{cyc: 32'(g + 1), idx: 5'(g)});
      exp_xwr = 1;
      exp_xwr_cyc = 34;
      exp_end = 35;
    end else if (lat >= 1 && lat <= RD_TIMEOUT) begin
      exp_rd = 1;
      for (int k = 0; k < 32; k++)
        exp_wr.push_back('{cyc: 32'(2 + lat + k), sel: op[0], idx: 5'(k), data: row_w[k]});
      exp_end = 34 + lat;
    end else begin
      exp_rd = 1;
      exp_err = 1;
      exp_end = 2 + RD_TIMEOUT;
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [13:0] addr, input int lat,
                         input bit hold, input bit noise, input int rst_cyc);
    logic [1023:0] rbits;
    int rv_at;
    bit pend;
    logic [4:0] pidx;
    bit noise_ok;
    rv_at = 0;
    pend = 0;
    pidx = '0;
    wr_q.delete();
    rden_q.delete();
    rd_n = 0; rd_cyc = 0; rd_addr = '0;
    xwr_n = 0; xwr_cyc = 0; xwr_addr = '0; xwr_data = '0;
    done_n = 0; err_n = 0; overlap_n = 0; act_end = 0; ready_busy = 0;
    act_is_err = 0; ready_after = 0;
    for (int k = 0; k < 32; k++) rbits[32*k +: 32] = row_w[k];

    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = addr;
    @(posedge clk);
    #1;
    cmd_valid = hold;
    cmd_op = 2'($urandom_range(0, 3));
    cmd_addr = 14'($urandom);
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (xbox_rd) begin
        rd_n++;
        if (rd_n == 1) begin rd_cyc = c; rd_addr = xbox_addr; end
        if (lat != 0) rv_at = c + lat;
      end
      if (rf_wr_en) wr_q.push_back('{cyc: 32'(c), sel: rf_wr_sel, idx: rf_wr_idx, data: rf_wr_data});
      if (rf_rd_en) rden_q.push_back('{cyc: 32'(c), idx: rf_rd_idx});
      if (xbox_wr) begin
        xwr_n++;
        xwr_cyc = c;
        xwr_addr = xbox_addr;
        xwr_data = xbox_wdata;
      end
      if (done) done_n++;
      if (err) err_n++;
      if (done && err) overlap_n++;
      if ((done || err) && act_end == 0) begin
        act_end = c;
        act_is_err = err;
      end
      if ((act_end == 0 || c <= act_end) && cmd_ready) ready_busy++;
      if (act_end != 0 && c == act_end + 1) ready_after = cmd_ready;

      if (c == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset_outputs");
        break;
      end

      noise_ok = noise && (op[1] || (rv_at != 0 && c > rv_at));
      xbox_rvalid = (c == rv_at) || (noise_ok && ($urandom_range(0, 3) == 0));
      xbox_rdata = (c == rv_at) ? rbits : ~rbits;
      rf_rd_data = pend ? ra[pidx] : $urandom;
      pend = rf_rd_en;
      pidx = rf_rd_idx;
      cmd_valid = hold && (act_end == 0 || c <= act_end);
      cmd_op = 2'($urandom_range(0, 3));
      cmd_addr = 14'($urandom);
      if (act_end != 0 && c == act_end + 2) break;
    end
    cmd_valid = 1'b0;
    xbox_rvalid = 1'b0;
  endtask

  task automatic check_cmd(input logic [13:0] addr);
    chk("end_cycle", act_end, exp_end);
    chk("err_flag", act_is_err, exp_err);
    chk("pulse_count", done_n + err_n, 1);
    chk("done_err_overlap", overlap_n, 0);
    chk("ready_while_busy", ready_busy, 0);
    chk("ready_after_fin", ready_after, 1'b1);
    chk("xbox_rd_count", rd_n, exp_rd ? 1 : 0);
    if (rd_n == 1 && exp_rd) begin
      chk("xbox_rd_cycle", rd_cyc, 1);
      chk("xbox_rd_addr", rd_addr, addr);
    end
    chk("rf_wr_count", wr_q.size(), exp_wr.size());
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
      chk("rf_wr_event", wr_q[i], exp_wr[i]);
    chk("rf_rd_count", rden_q.size(), exp_rden.size());
    for (int i = 0; i < rden_q.size() && i < exp_rden.size(); i++)
      chk("rf_rd_event", rden_q[i], exp_rden[i]);
    chk("xbox_wr_count", xwr_n, exp_xwr ? 1 : 0);
    if (xwr_n == 1 && exp_xwr) begin
      chk("xbox_wr_cycle", xwr_cyc, exp_xwr_cyc);
      chk("xbox_wr_addr", xwr_addr, addr);
      for (int g = 0; g < 32; g++) chk("xbox_wdata_word", xwr_data[32*g +: 32], ra[g]);
    end
  endtask

  vec_t tbl[7];

  initial begin
    logic [1:0] r_op;
    logic [13:0] r_addr;
    int r_lat;
    int fw;
    int post_done;

    tbl[0] = '{2'b00, 14'h0123, 3,   0, 32'hA500_0000, 37,  0, 5,   32, 0};
    tbl[1] = '{2'b01, 14'h3FFF, 1,   0, 32'h5A00_0000, 35,  0, 3,   32, 0};
    tbl[2] = '{2'b10, 14'h0040, 0,   0, 32'h0000_1000, 35,  0, 0,   0,  34};
    tbl[3] = '{2'b00, 14'h0000, 0,   0, 32'hC300_0000, 258, 1, 0,   0,  0};
    tbl[4] = '{2'b11, 14'h1234, 0,   0, 32'h0000_0000, 1,   1, 0,   0,  0};
    tbl[5] = '{2'b01, 14'h0000, 256, 0, 32'h7700_0000, 290, 0, 258, 32, 0};
    tbl[6] = '{2'b10, 14'h3FFF, 0,   1, 32'hDEAD_0000, 35,  0, 0,   0,  34};

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_addr = '0;
    xbox_rdata = '0;
    xbox_rvalid = 1'b0;
    rf_rd_data = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 7; t++) begin
      for (int k = 0; k < 32; k++) begin
        row_w[k] = tbl[t].base + 32'(k);
        ra[k] = tbl[t].base + 32'(k);
      end
      build_expect(tbl[t].op, tbl[t].lat);
      run_cmd(tbl[t].op, tbl[t].addr, tbl[t].lat, tbl[t].hold, 0, 0);
      check_cmd(tbl[t].addr);
      fw = (wr_q.size() > 0) ? int'(wr_q[0].cyc) : 0;
      chk("tbl_end", act_end, tbl[t].t_end);
      chk("tbl_err", act_is_err, tbl[t].t_err);
      chk("tbl_first_wr", fw, tbl[t].t_first_wr);
      chk("tbl_nwr", wr_q.size(), tbl[t].t_nwr);
      chk("tbl_xwr_cycle", xwr_cyc, tbl[t].t_xwr);
    end

    // Reset on the 10th unpack write: L=2 puts writes at cycles 4.., so the 10th is cycle 13.
    for (int k = 0; k < 32; k++) row_w[k] = 32'hBEEF_0000 + 32'(k);
    build_expect(2'b00, 2);
    run_cmd(2'b00, 14'h0555, 2, 0, 0, 13);
    chk("reset_wr_count", wr_q.size(), 10);
    for (int i = 0; i < wr_q.size() && i < 10; i++) chk("reset_wr_event", wr_q[i], exp_wr[i]);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    post_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) chk("ready_after_reset", cmd_ready, 1'b1);
      if (done) post_done++;
    end
    chk("no_done_after_reset", done_n + post_done, 0);
    for (int k = 0; k < 32; k++) row_w[k] = 32'h0F0F_0000 + 32'(k);
    build_expect(2'b01, 4);
    run_cmd(2'b01, 14'h2AAA, 4, 0, 0, 0);
    check_cmd(14'h2AAA);

    for (int n = 0; n < 24; n++) begin
      r_op = 2'($urandom_range(0, 3));
      r_addr = 14'($urandom);
      r_lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      for (int k = 0; k < 32; k++) begin
        row_w[k] = $urandom;
        ra[k] = $urandom;
      end
      build_expect(r_op, r_lat);
      run_cmd(r_op, r_addr, r_lat, 1'($urandom_range(0, 1)), 1, 0);
      check_cmd(r_addr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tpum_xbox_row_mover.md
Name: tpum_xbox_row_mover

Overview:
- Data-movement stage directly downstream of the TPUM control FSM.
- Executes one command at a time:
  - LOAD_R1 / LOAD_R2: fetch one 1024-bit XBOX row, then write it into the R1 or R2 word bank (32 x 32-bit) one word per cycle.
  - STORE_RA: gather the 32 RA words, then write them to XBOX as one row.
- Owns the XBOX read/write port. The control FSM only issues commands and waits for done or err.

Parameters:
- ADDR_W, 14, XBOX row address width.
- ROW_W, 1024, XBOX row width in bits.
- WORD_W, 32, register word width. ROW_W/WORD_W = 32 words per row.
- RD_TIMEOUT, 256, maximum cycles in RD_WAIT before the read is aborted with err.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00=LOAD_R1, 01=LOAD_R2, 10=STORE_RA, 11=reserved.
- cmd_addr  in  ADDR_W  XBOX row address.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on reserved op or read timeout.
- xbox_rd  out  1  one-cycle read strobe.
- xbox_wr  out  1  one-cycle write strobe.
- xbox_addr  out  ADDR_W  row address, held for the whole command.
- xbox_wdata  out  ROW_W  write row; valid while xbox_wr=1.
- xbox_rdata  in  ROW_W  read row; sampled when xbox_rvalid=1.
- xbox_rvalid  in  1  read data valid.
- rf_wr_en  out  1  bank word write enable.
- rf_wr_sel  out  1  0=R1, 1=R2.
- rf_wr_idx  out  5  word index.
- rf_wr_data  out  WORD_W  word data.
- rf_rd_en  out  1  RA word read request.
- rf_rd_idx  out  5  RA word index.
- rf_rd_data  in  WORD_W  RA word; valid exactly 1 cycle after rf_rd_en.

Behaviour:
- Reset (rst_n asynchronous, active-low; clock clk):
  - State goes to IDLE.
  - All outputs are 0, except cmd_ready=1.
  - Row buffer, counters and latched cmd are cleared.
- States: IDLE, RD_REQ, RD_WAIT, UNPACK, GATHER, WR_REQ, FIN.
- IDLE: cmd_valid && cmd_ready latches op and addr at the clock edge (acceptance edge = cycle 0).
  - op 00 or 01 -> RD_REQ.
  - op 10 -> GATHER.
  - op 11 -> FIN with err. No XBOX or RF access.
- RD_REQ: xbox_rd=1 for exactly cycle 1. xbox_addr=cmd_addr. -> RD_WAIT.
- RD_WAIT:
  - Waits for xbox_rvalid, then captures xbox_rdata into the row buffer -> UNPACK.
  - A timeout counter increments each cycle in this state. On reaching RD_TIMEOUT cycles -> FIN with err; the RF is left untouched.
  - xbox_rvalid in any other state is ignored.
- UNPACK: 32 cycles, index k = 0..31.
  - rf_wr_en=1, rf_wr_idx=k, rf_wr_data=row[32k+31:32k], rf_wr_sel=op[0].
  - Ascending order, no gaps. After k=31 -> FIN.
- GATHER: 33 cycles.
  - Cycles g = 0..31: rf_rd_en=1, rf_rd_idx=g.
  - Cycles g+1: rf_rd_data is written into row[32g+31:32g].
  - -> WR_REQ.
- WR_REQ: xbox_wr=1 for one cycle, with xbox_addr=cmd_addr and xbox_wdata=assembled row. -> FIN.
- FIN: done=1 (or err=1) for one cycle. done and err are never high together. -> IDLE.
- Latency:
  - Load with rvalid L cycles after xbox_rd (L >= 1): xbox_rd at cycle 1, writes at cycles 2+L .. 33+L, done at 34+L.
  - Store: rd_en at cycles 1..32, xbox_wr at cycle 34, done at 35.
  - Reserved op: err at cycle 1.
- Width and counters:
  - Word counter is 6 bits; terminal value 32.
  - Timeout counter is clog2(RD_TIMEOUT)+1 bits and saturates.
  - No arithmetic on data; words pass through bit-exact.
- Boundary conditions:
  - cmd_valid while busy: cmd_ready=0 and nothing is latched.
  - A held cmd_valid in FIN is not accepted until IDLE. Back-to-back commands therefore have ≥1 IDLE cycle.
  - cmd_addr changes after acceptance have no effect.
  - Addresses 0 and 2^ADDR_W-1 are legal; there is no wrap or offset.
  - rvalid in the same cycle the timeout is reached: data wins and is captured. Normal completion follows.
  - Reset mid-UNPACK: writes stop immediately. Already-written words remain in the bank; no done.
  - Reset mid-GATHER or WR_REQ: no XBOX write occurs.

Decomposition:
- tpum_pkg holds:
  - Typedef mover_op_e (LOAD_R1, LOAD_R2, STORE_RA, RSVD).
  - Typedef mover_state_e, one-hot, 7 bits.
  - Constants XBOX_ADDR_W=14, XBOX_ROW_W=1024, RF_WORD_W=32, ROW_WORDS=32.
- One sub-module: tpum_row_buffer.
  - 1024-bit register with full-row load (from xbox_rdata).
  - Word write port (idx, data) for the gather path.
  - Word read mux (idx) for the unpack path.
  - Async reset to 0.
- The FSM, counters and handshakes stay in tpum_xbox_row_mover.

Test Plan:
- LOAD_R1, addr=0x0123. Memory returns row with word k = 0xA5000000+k at L=3.
  -> xbox_rd pulse at cycle 1 with addr 0x0123.
  -> 32 writes, sel=0, idx 0..31, data 0xA5000000..0xA500001F, cycles 5..36.
  -> done at 37.
- LOAD_R2, addr=0x3FFF, L=1. -> rf_wr_sel=1, writes at cycles 3..34, done at 35, cmd_ready=0 throughout.
- STORE_RA, addr=0x0040. RA word g = 0x1000+g.
  -> rf_rd_idx 0..31 at cycles 1..32.
  -> xbox_wr at cycle 34 with wdata[32g+31:32g]=0x1000+g.
  -> done at 35.
- LOAD_R1, memory never asserts rvalid, RD_TIMEOUT=256.
  -> err pulse after 256 cycles in RD_WAIT, no rf_wr_en, done stays 0.
  -> Next cmd is accepted.
- cmd_op=11. -> err at cycle 1; xbox_rd, xbox_wr, rf_wr_en and rf_rd_en all stay 0.
- Reset asserted at the 10th UNPACK write. -> outputs 0 asynchronously, cmd_ready=1 after release, no done.
  -> A following LOAD_R2 completes normally.
